// File: rtl/color_sim_pkg.sv
// Shared types and constants for the coloring-simulation sequencer: symbol
// encoding, colored clock levels, FSM states and the per-step result classes.
package color_sim_pkg;

  localparam int BW_DEFAULT = 63;

  localparam logic [1:0] SYM_UNK  = 2'b00;
  localparam logic [1:0] SYM_CONF = 2'b01;
  localparam logic [1:0] SYM_0    = 2'b10;
  localparam logic [1:0] SYM_1    = 2'b11;

  localparam logic [1:0] CLK_LO = 2'd2;
  localparam logic [1:0] CLK_HI = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    COMPARE,
    DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_CORRECT,
    CLS_WRONG,
    CLS_ERROR,
    CLS_PANIC
  } step_class_e;

  function automatic logic symValid(input logic [1:0] sym);
    return !((sym == SYM_UNK) || (sym == SYM_CONF));
  endfunction

  // A single bad lane decides the whole step, so the most severe class wins.
  function automatic step_class_e reduceClass(input logic anyPanic,
                                              input logic anyError,
                                              input logic anyWrong);
    if (anyPanic) return CLS_PANIC;
    if (anyError) return CLS_ERROR;
    if (anyWrong) return CLS_WRONG;
    return CLS_CORRECT;
  endfunction

endpackage

// File: rtl/color_clk_gen.sv
// Colored clock generator: every lane carries the same 2/3 level, toggling
// every half_i cycles while enabled and parked at 0 otherwise.
module color_clk_gen
  import color_sim_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [7:0]  half_i,
  output logic [BW:0] clk_o
);

  logic [7:0] phase_q, phase_d;
  logic [7:0] lastPhase;
  logic       level_q, level_d;
  logic [1:0] levelSym;

  // A half-period of 0 behaves like 1, i.e. toggle on every cycle.
  assign lastPhase = (half_i == 8'd0) ? 8'd0 : half_i - 8'd1;

  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    if (!enable_i) begin
      phase_d = '0;
      level_d = 1'b0;
    end else if (phase_q >= lastPhase) begin
      phase_d = '0;
      level_d = !level_q;
    end else begin
      phase_d = phase_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      level_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
    end
  end

  assign levelSym = level_q ? CLK_HI : CLK_LO;
  assign clk_o    = enable_i ? {((BW + 1) / 2){levelSym}} : '0;

endmodule

// File: rtl/color_seq_ctrl.sv
// Run sequencer and scorer: feeds stimulus words to the datapath, waits a
// settle window, classifies qbad against qgood and keeps per-run counters.
module color_seq_ctrl
  import color_sim_pkg::*;
#(
  parameter int BW = BW_DEFAULT,
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     n_steps,
  input  logic [3:0]      settle,
  input  logic [7:0]      clk0_half,
  input  logic [7:0]      clk1_half,
  input  logic            stim_valid,
  input  logic [4*BW+3:0] stim_data,
  output logic            stim_ready,
  output logic [BW:0]     aaa,
  output logic [BW:0]     bbb,
  output logic [BW:0]     ccc,
  output logic [BW:0]     eee,
  output logic [BW:0]     clk0,
  output logic [BW:0]     clk1,
  input  logic [BW:0]     qbad,
  input  logic [BW:0]     qgood,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   corrects,
  output logic [CW-1:0]   wrongs,
  output logic [CW-1:0]   errors,
  output logic [CW-1:0]   panics
);

  localparam int W  = BW + 1;
  localparam int NL = W / 2;

  seq_state_e      state_q, state_d;
  logic [15:0]     nSteps_q, nSteps_d;
  logic [15:0]     stepIdx_q, stepIdx_d;
  logic [3:0]      settle_q, settle_d;
  logic [3:0]      settleCnt_q, settleCnt_d;
  logic [7:0]      half0_q, half0_d;
  logic [7:0]      half1_q, half1_d;
  logic [4*W-1:0]  stimWord_q, stimWord_d;
  logic [CW-1:0]   corrects_q, corrects_d;
  logic [CW-1:0]   wrongs_q, wrongs_d;
  logic [CW-1:0]   errors_q, errors_d;
  logic [CW-1:0]   panics_q, panics_d;

  logic [NL-1:0]   lanePanic, laneError, laneWrong;
  step_class_e     stepClass;

  function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
    return (&v) ? v : v + {{(CW - 1){1'b0}}, 1'b1};
  endfunction

  // Every lane is judged independently; the package function folds them.
  for (genvar l = 0; l < NL; l++) begin : g_lane
    logic [1:0] goodSym, badSym;
    assign goodSym      = qgood[2*l +: 2];
    assign badSym       = qbad[2*l +: 2];
    assign lanePanic[l] = !symValid(goodSym);
    assign laneError[l] = symValid(goodSym) && !symValid(badSym);
    assign laneWrong[l] = symValid(goodSym) && symValid(badSym) && (goodSym != badSym);
  end

  assign stepClass = reduceClass(|lanePanic, |laneError, |laneWrong);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nSteps_q    <= '0;
      stepIdx_q   <= '0;
      settle_q    <= '0;
      settleCnt_q <= '0;
      half0_q     <= '0;
      half1_q     <= '0;
      stimWord_q  <= '0;
      corrects_q  <= '0;
      wrongs_q    <= '0;
      errors_q    <= '0;
      panics_q    <= '0;
    end else begin
      state_q     <= state_d;
      nSteps_q    <= nSteps_d;
      stepIdx_q   <= stepIdx_d;
      settle_q    <= settle_d;
      settleCnt_q <= settleCnt_d;
      half0_q     <= half0_d;
      half1_q     <= half1_d;
      stimWord_q  <= stimWord_d;
      corrects_q  <= corrects_d;
      wrongs_q    <= wrongs_d;
      errors_q    <= errors_d;
      panics_q    <= panics_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nSteps_d    = nSteps_q;
    stepIdx_d   = stepIdx_q;
    settle_d    = settle_q;
    settleCnt_d = settleCnt_q;
    half0_d     = half0_q;
    half1_d     = half1_q;
    stimWord_d  = stimWord_q;
    corrects_d  = corrects_q;
    wrongs_d    = wrongs_q;
    errors_d    = errors_q;
    panics_d    = panics_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nSteps_d   = n_steps;
          settle_d   = settle;
          half0_d    = clk0_half;
          half1_d    = clk1_half;
          stepIdx_d  = '0;
          corrects_d = '0;
          wrongs_d   = '0;
          errors_d   = '0;
          panics_d   = '0;
          state_d    = (n_steps == 16'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (stim_valid && stim_ready) begin
          stimWord_d  = stim_data;
          settleCnt_d = settle_q;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt_q == 4'd0) begin
          state_d = COMPARE;
        end else begin
          settleCnt_d = settleCnt_q - 4'd1;
        end
      end
      COMPARE: begin
        unique case (stepClass)
          CLS_CORRECT: corrects_d = satInc(corrects_q);
          CLS_WRONG:   wrongs_d   = satInc(wrongs_q);
          CLS_ERROR:   errors_d   = satInc(errors_q);
          CLS_PANIC:   panics_d   = satInc(panics_q);
          default:     ;
        endcase
        stepIdx_d = stepIdx_q + 16'd1;
        state_d   = (stepIdx_d == nSteps_q) ? DONE : LOAD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status flags come straight from the state register, so
  // stim_ready never depends combinationally on stim_valid.
  always_comb begin
    busy       = (state_q != IDLE);
    stim_ready = (state_q == LOAD);
    done       = (state_q == DONE);
  end

  assign aaa      = stimWord_q[0*W +: W];
  assign bbb      = stimWord_q[1*W +: W];
  assign ccc      = stimWord_q[2*W +: W];
  assign eee      = stimWord_q[3*W +: W];
  assign corrects = corrects_q;
  assign wrongs   = wrongs_q;
  assign errors   = errors_q;
  assign panics   = panics_q;

  color_clk_gen #(.BW(BW)) u_clk0_gen (
    .clk      (clk),
    .rst      (rst),
    .enable_i (busy),
    .half_i   (half0_q),
    .clk_o    (clk0)
  );

  color_clk_gen #(.BW(BW)) u_clk1_gen (
    .clk      (clk),
    .rst      (rst),
    .enable_i (busy),
    .half_i   (half1_q),
    .clk_o    (clk1)
  );

endmodule

// File: tb/tb_color_seq_ctrl.sv
// Self-checking bench for color_seq_ctrl: directed and randomized runs scored
// against a cycle-indexed reference model built from the run rules.
module tb_color_seq_ctrl;

  localparam int BW = 63;
  localparam int CW = 32;
  localparam int W  = BW + 1;
  localparam int NL = W / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [15:0]     n_steps;
  logic [3:0]      settle;
  logic [7:0]      clk0_half;
  logic [7:0]      clk1_half;
  logic            stim_valid;
  logic [4*W-1:0]  stim_data;
  logic            stim_ready;
  logic [W-1:0]    aaa, bbb, ccc, eee, clk0, clk1, qbad, qgood;
  logic            busy, done;
  logic [CW-1:0]   corrects, wrongs, errorsOut, panics;

  int              nChecks = 0;
  int              nErrors = 0;
  logic [4*W-1:0]  words[$];
  int              gaps[$];
  int unsigned     expCnt[4];
  logic [4*W-1:0]  modelWord;
  bit              pulseStart;

  // The datapath stand-in: aaa is the golden answer, bbb the answer under test.
  assign qgood = aaa;
  assign qbad  = bbb;

  always #5 clk = ~clk;

  color_seq_ctrl #(.BW(BW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_steps    (n_steps),
    .settle     (settle),
    .clk0_half  (clk0_half),
    .clk1_half  (clk1_half),
    .stim_valid (stim_valid),
    .stim_data  (stim_data),
    .stim_ready (stim_ready),
    .aaa        (aaa),
    .bbb        (bbb),
    .ccc        (ccc),
    .eee        (eee),
    .clk0       (clk0),
    .clk1       (clk1),
    .qbad       (qbad),
    .qgood      (qgood),
    .busy       (busy),
    .done       (done),
    .corrects   (corrects),
    .wrongs     (wrongs),
    .errors     (errorsOut),
    .panics     (panics)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int cyc,
                             input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [1:0] s);
    logic [W-1:0] r;
    for (int l = 0; l < NL; l++) r[2*l +: 2] = s;
    return r;
  endfunction

  // Step class: 0 correct, 1 wrong, 2 error, 3 panic; the worst lane decides.
  function automatic int refClass(input logic [W-1:0] good, input logic [W-1:0] bad);
    int worst;
    int c;
    logic [1:0] g, b;
    worst = 0;
    for (int l = 0; l < NL; l++) begin
      g = good[2*l +: 2];
      b = bad[2*l +: 2];
      if (g < 2'd2)      c = 3;
      else if (b < 2'd2) c = 2;
      else if (g != b)   c = 1;
      else               c = 0;
      if (c > worst) worst = c;
    end
    return worst;
  endfunction

  function automatic logic [4*W-1:0] randWord();
    logic [W-1:0] g, b, x, y;
    int lane, lane2;
    for (int l = 0; l < NL; l++) g[2*l +: 2] = {1'b1, 1'($urandom_range(0, 1))};
    b = g;
    lane  = $urandom_range(0, NL - 1);
    lane2 = $urandom_range(0, NL - 1);
    case ($urandom_range(0, 4))
      1: b[2*lane] = ~b[2*lane];
      2: b[2*lane +: 2] = 2'($urandom_range(0, 1));
      3: g[2*lane +: 2] = 2'($urandom_range(0, 1));
      4: begin
        b[2*lane]        = ~b[2*lane];
        b[2*lane2 +: 2]  = 2'($urandom_range(0, 1));
      end
      default: ;
    endcase
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    return {y, x, b, g};
  endfunction

  // One complete run: start, feed words[] with gaps[] cycles of valid low
  // before each handshake, and check every visible output each cycle.
  task automatic applyStimulus(input int n, input int st, input int h0, input int h1,
                               input int rstAt);
    int loadAt, doneCycle, cmpCycle, wordAt, stepIn, waitLeft, pendCls, he0, he1;
    logic [4*W-1:0] pendWord, cur;
    logic [W-1:0] expC0, expC1;
    bit expReady, expBusy, finished;
    he0 = (h0 == 0) ? 1 : h0;
    he1 = (h1 == 0) ? 1 : h1;
    n_steps = 16'(n); settle = 4'(st); clk0_half = 8'(h0); clk1_half = 8'(h1);
    stim_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) expCnt[c] = 0;
    loadAt    = (n == 0) ? -1 : 0;
    doneCycle = (n == 0) ? 0 : -1;
    cmpCycle = -1; wordAt = -1; stepIn = 0; pendCls = 0; pendWord = '0;
    waitLeft = (gaps.size() > 0) ? gaps[0] : 0;
    finished = 1'b0;
    for (int k = 0; k < 3000 && !finished; k++) begin
      if (k == wordAt) modelWord = pendWord;
      if (k == cmpCycle) expCnt[pendCls]++;
      expReady = (loadAt >= 0) && (k >= loadAt);
      expBusy  = (doneCycle < 0) || (k <= doneCycle);
      expC0 = expBusy ? rep(((k / he0) % 2 == 1) ? 2'd3 : 2'd2) : '0;
      expC1 = expBusy ? rep(((k / he1) % 2 == 1) ? 2'd3 : 2'd2) : '0;
      checkOutput("busy", k, busy, expBusy);
      checkOutput("stim_ready", k, stim_ready, expReady);
      checkOutput("done", k, done, (k == doneCycle));
      checkOutput("clk0", k, clk0, expC0);
      checkOutput("clk1", k, clk1, expC1);
      checkOutput("stimulus", k, {eee, ccc, bbb, aaa}, modelWord);
      checkOutput("counters", k, {corrects, wrongs, errorsOut, panics},
                  {32'(expCnt[0]), 32'(expCnt[1]), 32'(expCnt[2]), 32'(expCnt[3])});
      if (doneCycle >= 0 && k > doneCycle) begin
        finished = 1'b1;
      end else if (k == rstAt) begin
        start = 1'b0; stim_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_busy", k, busy, 1'b0);
        checkOutput("rst_done", k, done, 1'b0);
        checkOutput("rst_ready", k, stim_ready, 1'b0);
        checkOutput("rst_clocks", k, {clk1, clk0}, '0);
        checkOutput("rst_stimulus", k, {eee, ccc, bbb, aaa}, '0);
        checkOutput("rst_counters", k, {corrects, wrongs, errorsOut, panics}, '0);
        modelWord = '0;
        for (int c = 0; c < 4; c++) expCnt[c] = 0;
        finished = 1'b1;
      end else begin
        start = 1'b0;
        if (k == doneCycle) begin
          start   = 1'b1;
          n_steps = 16'd5;
        end
        if (expReady) begin
          if (waitLeft > 0) begin
            stim_valid = 1'b0;
            waitLeft--;
            if (pulseStart && $urandom_range(0, 1) == 1) start = 1'b1;
          end else begin
            cur        = words[stepIn];
            stim_valid = 1'b1;
            stim_data  = cur;
            pendWord   = cur;
            wordAt     = k + 1;
            pendCls    = refClass(cur[W-1:0], cur[2*W-1:W]);
            cmpCycle   = k + st + 3;
            stepIn++;
            if (stepIn == n) begin
              doneCycle = k + st + 3;
              loadAt    = -1;
            end else begin
              loadAt   = k + st + 3;
              waitLeft = (gaps.size() > stepIn) ? gaps[stepIn] : 0;
            end
          end
        end else begin
          stim_valid = 1'b1;
          for (int i = 0; i < 8; i++) stim_data[32*i +: 32] = $urandom;
        end
        tick();
      end
    end
    start = 1'b0;
    stim_valid = 1'b0;
    checkOutput("run_finished", 0, finished, 1'b1);
  endtask

  initial begin
    logic [W-1:0] gw, bw;
    int n, st;
    rst = 1'b1; start = 1'b0; stim_valid = 1'b0; stim_data = '0;
    n_steps = '0; settle = '0; clk0_half = '0; clk1_half = '0;
    modelWord = '0; pulseStart = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset_flags", 0, {busy, done, stim_ready}, 3'b000);
    checkOutput("reset_counters", 0, {corrects, wrongs, errorsOut, panics}, '0);
    checkOutput("reset_stimulus", 0, {eee, ccc, bbb, aaa}, '0);
    repeat (20) tick();
    checkOutput("idle_flags", 20, {busy, done, stim_ready}, 3'b000);
    checkOutput("idle_clocks", 20, {clk1, clk0}, '0);

    $display("[TB] three correct steps");
    words.delete(); gaps.delete();
    for (int i = 0; i < 3; i++) words.push_back({randWord() >> (2 * W), rep(2'b10), rep(2'b10)});
    applyStimulus(3, 2, 4, 5, -1);
    checkOutput("plan_correct", 0, {corrects, wrongs, errorsOut, panics},
                {32'd3, 32'd0, 32'd0, 32'd0});

    $display("[TB] wrong, error, panic");
    words.delete();
    gw = rep(2'b10); gw[11:10] = 2'b11;
    words.push_back({128'h0, rep(2'b10), gw});
    bw = rep(2'b10); bw[1:0] = 2'b00;
    words.push_back({128'h0, bw, rep(2'b10)});
    gw = rep(2'b10); gw[7:6] = 2'b01;
    bw = rep(2'b10); bw[15:14] = 2'b11;
    words.push_back({128'h0, bw, gw});
    applyStimulus(3, 1, 3, 3, -1);
    checkOutput("plan_classes", 0, {corrects, wrongs, errorsOut, panics},
                {32'd0, 32'd1, 32'd1, 32'd1});

    $display("[TB] clock half periods");
    words.delete(); gaps.delete();
    words.push_back(randWord()); words.push_back(randWord());
    gaps.push_back(5); gaps.push_back(0);
    applyStimulus(2, 15, 7, 13, -1);
    gaps.delete();
    applyStimulus(2, 4, 0, 1, -1);

    $display("[TB] stalled handshake with ignored starts");
    words.delete(); gaps.delete();
    for (int i = 0; i < 3; i++) words.push_back(randWord());
    gaps.push_back(10); gaps.push_back(0); gaps.push_back(3);
    pulseStart = 1'b1;
    applyStimulus(3, 0, 2, 3, -1);
    pulseStart = 1'b0;

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 6);
      st = $urandom_range(0, 15);
      words.delete(); gaps.delete();
      for (int i = 0; i < n; i++) begin
        words.push_back(randWord());
        gaps.push_back($urandom_range(0, 3));
      end
      pulseStart = 1'($urandom_range(0, 1));
      applyStimulus(n, st, $urandom_range(0, 9), $urandom_range(0, 9), -1);
    end
    pulseStart = 1'b0;

    $display("[TB] empty run");
    words.delete(); gaps.delete();
    applyStimulus(0, 3, 2, 2, -1);

    $display("[TB] reset during second settle, then fresh run");
    for (int i = 0; i < 4; i++) words.push_back(randWord());
    applyStimulus(4, 3, 2, 3, 8);
    words.delete();
    words.push_back(randWord()); words.push_back(randWord());
    applyStimulus(2, 1, 1, 2, -1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
